// File: rtl/avr_sample_spi_master_pkg.sv
// Shared frame constants, FSM encoding and frame packing
// for the sample-link SPI master.
package avr_sample_spi_master_pkg;

  localparam int FRAME_BITS = 16;
  localparam int SAMPLE_W   = 10;
  localparam int CHAN_W     = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_GAP
  } state_e;

  // byte0 = sample[7:0], byte1 = {chan, 2'b00, sample[9:8]}
  function automatic logic [FRAME_BITS-1:0] pack_frame(
    input logic [SAMPLE_W-1:0] s,
    input logic [CHAN_W-1:0]   c
  );
    return {s[7:0], c, 2'b00, s[9:8]};
  endfunction

endpackage

// File: rtl/avr_sample_spi_master_sck_gen.sv
// SCK generator: half-period counter with rise/fall strobes.
// Strobes fire on the last cycle of a half-period.
module spi_sck_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic sck_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          lvl_q, lvl_d;
  logic          wrap;

  assign wrap   = en_i && (cnt_q == CW'(CLK_DIV - 1));
  assign rise_o = wrap && !lvl_q;
  assign fall_o = wrap && lvl_q;
  assign sck_o  = lvl_q;

  always_comb begin
    cnt_d = cnt_q;
    lvl_d = lvl_q;
    if (!en_i) begin
      cnt_d = '0;
      lvl_d = 1'b0;
    end else if (wrap) begin
      cnt_d = '0;
      lvl_d = !lvl_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      lvl_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      lvl_q <= lvl_d;
    end
  end

endmodule

// File: rtl/avr_sample_spi_master.sv
// Mode-0 SPI master sending {sample, channel} as two bytes
// under one SS assertion and capturing the returned bytes.
module avr_sample_spi_master
  import avr_sample_spi_master_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int GAP     = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                new_sample,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic [CHAN_W-1:0]   sample_channel,
  output logic                busy,
  output logic                done,
  output logic [15:0]         miso_data,
  output logic                spi_sck,
  output logic                spi_mosi,
  output logic                spi_ss,
  input  logic                spi_miso
);

  localparam int WMAX = (CLK_DIV > GAP) ? CLK_DIV : GAP;
  localparam int WW   = $clog2(WMAX);

  state_e                  state_q, state_d;
  logic [WW-1:0]           wcnt_q, wcnt_d;
  logic [3:0]              bit_q, bit_d;
  logic [FRAME_BITS-1:0]   tx_q, tx_d;
  logic [FRAME_BITS-1:0]   rx_q, rx_d;
  logic [15:0]             md_q, md_d;
  logic                    done_q, done_d;
  logic                    rise, fall, sck;
  logic                    ss_act;

  spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck (
    .clk    (clk),
    .rst    (rst),
    .en_i   (state_q == ST_SHIFT),
    .sck_o  (sck),
    .rise_o (rise),
    .fall_o (fall)
  );

  assign ss_act    = (state_q == ST_SETUP) ||
                     (state_q == ST_SHIFT);
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign miso_data = md_q;
  assign spi_ss    = !ss_act;
  assign spi_sck   = sck;
  assign spi_mosi  = ss_act ? tx_q[FRAME_BITS-1] : 1'b0;

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    md_d    = md_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (new_sample) begin
          state_d = ST_SETUP;
          tx_d    = pack_frame(sample, sample_channel);
          wcnt_d  = '0;
          bit_d   = '0;
        end
      end
      ST_SETUP: begin
        if (wcnt_q == WW'(CLK_DIV - 1)) begin
          state_d = ST_SHIFT;
          wcnt_d  = '0;
        end else begin
          wcnt_d = wcnt_q + WW'(1);
        end
      end
      ST_SHIFT: begin
        if (rise) rx_d = {rx_q[FRAME_BITS-2:0], spi_miso};
        if (fall) begin
          tx_d  = {tx_q[FRAME_BITS-2:0], 1'b0};
          bit_d = bit_q + 4'd1;
          // last fall: rx already holds all 16 bits
          if (bit_q == 4'd15) begin
            state_d = ST_GAP;
            done_d  = 1'b1;
            md_d    = rx_q;
            wcnt_d  = '0;
          end
        end
      end
      ST_GAP: begin
        if (wcnt_q == WW'(GAP - 1)) begin
          state_d = ST_IDLE;
        end else begin
          wcnt_d = wcnt_q + WW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      wcnt_q  <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      md_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      md_q    <= md_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_avr_sample_spi_master.sv
// Directed bench for avr_sample_spi_master: one DUT at
// CLK_DIV=4 plus CLK_DIV=2 and CLK_DIV=7 loopback DUTs.
module tb_avr_sample_spi_master;

  logic        clk = 1'b0;
  logic [2:0]  rst_r;
  logic [2:0]  ns_r;
  logic [2:0]  miso_r;
  logic [9:0]  smp [3];
  logic [3:0]  chn [3];
  logic [2:0]  busy_w, done_w, sck_w, mosi_w, ss_w;
  logic [15:0] md_w [3];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  avr_sample_spi_master #(.CLK_DIV(4), .GAP(2)) u0 (
    .clk(clk), .rst(rst_r[0]), .new_sample(ns_r[0]),
    .sample(smp[0]), .sample_channel(chn[0]),
    .busy(busy_w[0]), .done(done_w[0]),
    .miso_data(md_w[0]), .spi_sck(sck_w[0]),
    .spi_mosi(mosi_w[0]), .spi_ss(ss_w[0]),
    .spi_miso(miso_r[0])
  );

  avr_sample_spi_master #(.CLK_DIV(2), .GAP(2)) u1 (
    .clk(clk), .rst(rst_r[1]), .new_sample(ns_r[1]),
    .sample(smp[1]), .sample_channel(chn[1]),
    .busy(busy_w[1]), .done(done_w[1]),
    .miso_data(md_w[1]), .spi_sck(sck_w[1]),
    .spi_mosi(mosi_w[1]), .spi_ss(ss_w[1]),
    .spi_miso(miso_r[1])
  );

  avr_sample_spi_master #(.CLK_DIV(7), .GAP(2)) u2 (
    .clk(clk), .rst(rst_r[2]), .new_sample(ns_r[2]),
    .sample(smp[2]), .sample_channel(chn[2]),
    .busy(busy_w[2]), .done(done_w[2]),
    .miso_data(md_w[2]), .spi_sck(sck_w[2]),
    .spi_mosi(mosi_w[2]), .spi_ss(ss_w[2]),
    .spi_miso(miso_r[2])
  );

  // Runs one frame on DUT k with a mode-0 slave model.
  task automatic xfer(
    input  int          k,
    input  logic [9:0]  s,
    input  logic [3:0]  c,
    input  logic [15:0] mpat,
    input  int          pulse_at,
    output logic [15:0] mo,
    output logic [15:0] md,
    output int          ss_low,
    output int          dones,
    output int          done_at,
    output int          busy_n,
    output int          min_setup,
    output int          sck_bad
  );
    int n;
    int since;
    logic psck, pm;
    logic [15:0] mp;
    mo = '0; md = '0; ss_low = 0; dones = 0;
    done_at = -1; busy_n = 0; min_setup = 1000;
    sck_bad = 0; mp = mpat;
    @(negedge clk);
    smp[k] = s; chn[k] = c; ns_r[k] = 1'b1;
    psck = sck_w[k]; pm = mosi_w[k]; since = 1;
    @(negedge clk);
    ns_r[k] = 1'b0;
    miso_r[k] = mp[15];
    for (n = 1; n < 2000; n++) begin
      if (mosi_w[k] == pm) since++;
      else since = 1;
      if (!ss_w[k]) ss_low++;
      else if (sck_w[k]) sck_bad++;
      if (busy_w[k]) busy_n++;
      if (done_w[k]) begin
        dones++;
        if (done_at < 0) done_at = n;
        md = md_w[k];
      end
      if (sck_w[k] && !psck) begin
        mo = {mo[14:0], mosi_w[k]};
        if (since - 1 < min_setup) min_setup = since - 1;
      end
      if (!sck_w[k] && psck) begin
        mp = {mp[14:0], 1'b0};
        miso_r[k] = mp[15];
      end
      if (n == pulse_at) begin
        smp[k] = ~s; chn[k] = ~c; ns_r[k] = 1'b1;
      end
      if (n == pulse_at + 1) ns_r[k] = 1'b0;
      if (!busy_w[k]) break;
      psck = sck_w[k]; pm = mosi_w[k];
      @(negedge clk);
    end
    ns_r[k] = 1'b0;
    miso_r[k] = 1'b0;
    if (n >= 2000) begin
      tests++; fails++;
      $display("FAIL xfer_timeout dut=%0d busy never fell", k);
    end
  endtask

  task automatic test_reset();
    rst_r = 3'b111; ns_r = '0; miso_r = '0;
    for (int i = 0; i < 3; i++) begin
      smp[i] = '0; chn[i] = '0;
    end
    repeat (3) @(negedge clk);
    rst_r = 3'b000;
    @(negedge clk);
    tests++;
    if (ss_w[0] !== 1'b1) begin
      fails++; $display("FAIL reset_ss got=%b exp=1", ss_w[0]);
    end
    tests++;
    if (sck_w[0] !== 1'b0) begin
      fails++; $display("FAIL reset_sck got=%b exp=0", sck_w[0]);
    end
    tests++;
    if (mosi_w[0] !== 1'b0) begin
      fails++; $display("FAIL reset_mosi got=%b exp=0", mosi_w[0]);
    end
    tests++;
    if (busy_w[0] !== 1'b0) begin
      fails++; $display("FAIL reset_busy got=%b exp=0", busy_w[0]);
    end
    tests++;
    if (done_w[0] !== 1'b0) begin
      fails++; $display("FAIL reset_done got=%b exp=0", done_w[0]);
    end
    tests++;
    if (md_w[0] !== 16'h0000) begin
      fails++; $display("FAIL reset_miso_data got=%h exp=0000", md_w[0]);
    end
    tests++;
    if ({ss_w[2:1], busy_w[2:1]} !== 4'b1100) begin
      fails++;
      $display("FAIL reset_aux got=%b exp=1100", {ss_w[2:1], busy_w[2:1]});
    end
  endtask

  task automatic test_single_frame();
    logic [15:0] mo, md;
    int sl, dn, da, bn, ms, sb;
    xfer(0, 10'h2A5, 4'h3, 16'hFF5A, -10,
         mo, md, sl, dn, da, bn, ms, sb);
    tests++;
    if (mo !== 16'hA532) begin
      fails++; $display("FAIL single_mosi got=%h exp=a532", mo);
    end
    tests++;
    if (sl != 132) begin
      fails++; $display("FAIL single_ss_low got=%0d exp=132", sl);
    end
    tests++;
    if (dn != 1) begin
      fails++; $display("FAIL single_done_cnt got=%0d exp=1", dn);
    end
    tests++;
    if (da != 133) begin
      fails++; $display("FAIL single_done_at got=%0d exp=133", da);
    end
    tests++;
    if (bn != 134) begin
      fails++; $display("FAIL single_busy_len got=%0d exp=134", bn);
    end
    tests++;
    if (md !== 16'hFF5A) begin
      fails++; $display("FAIL miso_capture got=%h exp=ff5a", md);
    end
    tests++;
    if (ms < 4 || sb != 0) begin
      fails++;
      $display("FAIL single_mosi_setup got=%0d/%0d exp>=4/0", ms, sb);
    end
  endtask

  task automatic test_busy_drop();
    logic [15:0] mo, md;
    int sl, dn, da, bn, ms, sb, extra;
    xfer(0, 10'h11E, 4'h7, 16'h0F0F, 50,
         mo, md, sl, dn, da, bn, ms, sb);
    // 10'h11E, ch 7 -> bytes 1E, 71
    tests++;
    if (mo !== 16'h1E71) begin
      fails++; $display("FAIL busy_drop_mosi got=%h exp=1e71", mo);
    end
    tests++;
    if (dn != 1 || md !== 16'h0F0F) begin
      fails++;
      $display("FAIL busy_drop_done got=%0d/%h exp=1/0f0f", dn, md);
    end
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (!ss_w[0] || busy_w[0]) extra++;
    end
    tests++;
    if (extra != 0) begin
      fails++; $display("FAIL busy_drop_queued got=%0d exp=0", extra);
    end
  endtask

  task automatic test_back_to_back();
    int hi_run, gaps, bad_gap, sck_bad, dones, wait_n;
    logic seen_low;
    hi_run = 0; gaps = 0; bad_gap = 0; sck_bad = 0;
    dones = 0; seen_low = 1'b0;
    @(negedge clk);
    smp[0] = 10'h0F0; chn[0] = 4'h9; ns_r[0] = 1'b1;
    for (int n = 1; n <= 280; n++) begin
      @(negedge clk);
      if (done_w[0]) dones++;
      if (ss_w[0]) begin
        hi_run++;
        if (sck_w[0]) sck_bad++;
      end else begin
        if (seen_low && hi_run > 0) begin
          gaps++;
          // two GAP cycles plus the idle accept cycle
          if (hi_run != 3) bad_gap++;
        end
        hi_run = 0;
        seen_low = 1'b1;
      end
    end
    ns_r[0] = 1'b0;
    tests++;
    if (gaps != 2 || bad_gap != 0) begin
      fails++;
      $display("FAIL b2b_gap got=%0d/%0d exp=2/0", gaps, bad_gap);
    end
    tests++;
    if (sck_bad != 0) begin
      fails++; $display("FAIL b2b_sck_in_ss_high got=%0d exp=0", sck_bad);
    end
    tests++;
    if (dones != 2) begin
      fails++; $display("FAIL b2b_done_cnt got=%0d exp=2", dones);
    end
    wait_n = 0;
    while (busy_w[0] && wait_n < 500) begin
      @(negedge clk);
      wait_n++;
    end
    tests++;
    if (busy_w[0] !== 1'b0) begin
      fails++; $display("FAIL b2b_drain got=%b exp=0", busy_w[0]);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] mo, md;
    int sl, dn, da, bn, ms, sb, saw;
    saw = 0;
    @(negedge clk);
    smp[0] = 10'h155; chn[0] = 4'hA; ns_r[0] = 1'b1;
    @(negedge clk);
    ns_r[0] = 1'b0;
    // cycle 82 lies in the high half of bit 9
    for (int n = 1; n < 82; n++) begin
      if (done_w[0]) saw++;
      @(negedge clk);
    end
    tests++;
    if (sck_w[0] !== 1'b1 || ss_w[0] !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_pre got=%b%b exp=10", sck_w[0], ss_w[0]);
    end
    rst_r[0] = 1'b1;
    @(negedge clk);
    tests++;
    if ({ss_w[0], sck_w[0], busy_w[0], mosi_w[0]} !== 4'b1000) begin
      fails++;
      $display("FAIL rstmid_outs got=%b exp=1000",
               {ss_w[0], sck_w[0], busy_w[0], mosi_w[0]});
    end
    tests++;
    if (md_w[0] !== 16'h0000) begin
      fails++; $display("FAIL rstmid_md got=%h exp=0000", md_w[0]);
    end
    rst_r[0] = 1'b0;
    repeat (10) begin
      if (done_w[0]) saw++;
      @(negedge clk);
    end
    tests++;
    if (saw != 0) begin
      fails++; $display("FAIL rstmid_done got=%0d exp=0", saw);
    end
    xfer(0, 10'h3C7, 4'hC, 16'h1234, -10,
         mo, md, sl, dn, da, bn, ms, sb);
    tests++;
    if (mo !== 16'hC7C3 || md !== 16'h1234) begin
      fails++;
      $display("FAIL rstmid_clean got=%h/%h exp=c7c3/1234", mo, md);
    end
    tests++;
    if (dn != 1 || sl != 132) begin
      fails++;
      $display("FAIL rstmid_clean_frame got=%0d/%0d exp=1/132", dn, sl);
    end
  endtask

  task automatic test_loopback(input int k, input int cd);
    logic [15:0] mo, md, mpat;
    logic [9:0]  s, rs;
    logic [3:0]  c, rc;
    int sl, dn, da, bn, ms, sb;
    for (int i = 0; i < 50; i++) begin
      s = 10'($urandom_range(0, 1023));
      c = 4'($urandom_range(0, 15));
      mpat = 16'($urandom);
      xfer(k, s, c, mpat, -10,
           mo, md, sl, dn, da, bn, ms, sb);
      rs = {mo[1:0], mo[15:8]};
      rc = mo[7:4];
      tests++;
      if (rs !== s || rc !== c || mo[3:2] !== 2'b00 ||
          md !== mpat || dn != 1 || sl != 33 * cd ||
          ms < cd || sb != 0) begin
        fails++;
        $display("FAIL loopback_div%0d_%0d got=%h/%h/%h exp=%h/%h/%h",
                 cd, i, rs, rc, md, s, c, mpat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_busy_drop();
    test_back_to_back();
    test_reset_mid();
    test_loopback(1, 2);
    test_loopback(2, 7);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
